// File: rtl/char_motion_ctrl.sv
// Player-motion controller: frame-tick divider, clamped horizontal walk, jump/fall physics with gravity.
// Optional feature macro: CHAR_DOUBLE_JUMP_EN (one extra jump per airborne period).
module char_motion_ctrl #(
  parameter int W           = 12,
  parameter int FRAME_TICKS = 1_083_333,
  parameter int SPAWN_X     = 204,
  parameter int GROUND_Y    = 689,
  parameter int X_MIN       = 24,
  parameter int X_MAX       = 1000,
  parameter int Y_MIN       = 16,
  parameter int MOVE_STEP   = 5,
  parameter int JUMP_V      = 18,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [1:0]   game_active_i,
  input  logic         game_start_i,
  input  logic         stepleft_i,
  input  logic         stepright_i,
  input  logic         stepjump_i,
  input  logic         on_ground_i,
  output logic [W-1:0] pos_x_o,
  output logic [W-1:0] pos_y_o,
  output logic [7:0]   vel_y_o,
  output logic         flip_h_o,
  output logic         airborne_o,
  output logic         frame_tick_o
);

  localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int YW = W + 2;
  localparam logic signed [YW-1:0] Y_MIN_S    = YW'(Y_MIN);
  localparam logic signed [YW-1:0] GROUND_S   = YW'(GROUND_Y);
  localparam logic signed [7:0]    JUMP_VEL   = 8'(-JUMP_V);
  localparam logic signed [7:0]    GRAV_V     = 8'(GRAVITY);
  localparam logic signed [7:0]    MAX_FALL_V = 8'(MAX_FALL);

  typedef enum logic [1:0] {GROUNDED, RISE, FALL} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic               frame_tick_q, jump_prev_q, jump_req_q, flip_q;
  logic [W-1:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [7:0]  vel_q, vel_d, vel_inc, fall_v;
  logic signed [YW-1:0] y_ext, rise_sum, fall_sum;
  logic               frame_active, left_only, right_only, land, relaunch;

  assign frame_active = frame_tick_q && (game_active_i == 2'd1);
  assign left_only    = stepleft_i && !stepright_i;
  assign right_only   = stepright_i && !stepleft_i;

  assign y_ext    = $signed({2'b00, pos_y_q});
  assign vel_inc  = vel_q + GRAV_V;
  assign fall_v   = (vel_inc > MAX_FALL_V) ? MAX_FALL_V : vel_inc;
  assign rise_sum = y_ext + $signed({{(YW-8){vel_q[7]}}, vel_q});
  assign fall_sum = y_ext + $signed({{(YW-8){fall_v[7]}}, fall_v});
  assign land     = (state_q == FALL) && (on_ground_i || (fall_sum >= GROUND_S));

  function automatic logic [W-1:0] clamp_y(input logic signed [YW-1:0] y);
    if (y < Y_MIN_S)       return W'(Y_MIN);
    else if (y > GROUND_S) return W'(GROUND_Y);
    else                   return y[W-1:0];
  endfunction

`ifdef CHAR_DOUBLE_JUMP_EN
  logic dj_used_q, dj_used_d;

  assign relaunch = frame_active && jump_req_q && !dj_used_q && (state_q != GROUNDED);

  always_comb begin
    dj_used_d = dj_used_q;
    if (game_start_i)               dj_used_d = 1'b0;
    else if (relaunch)              dj_used_d = 1'b1;
    else if (frame_active && land)  dj_used_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) dj_used_q <= 1'b0;
    else         dj_used_q <= dj_used_d;
  end
`else
  assign relaunch = 1'b0;
`endif

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vel_d   = vel_q;
    state_d = state_q;
    if (game_start_i) begin
      pos_x_d = W'(SPAWN_X);
      pos_y_d = W'(GROUND_Y);
      vel_d   = '0;
      state_d = GROUNDED;
    end else if (frame_active) begin
      // Guard before subtracting / compare after adding in W+1 bits so x never wraps.
      if (left_only) begin
        if ({1'b0, pos_x_q} < (W+1)'(X_MIN + MOVE_STEP)) pos_x_d = W'(X_MIN);
        else                                             pos_x_d = pos_x_q - W'(MOVE_STEP);
      end else if (right_only) begin
        if (({1'b0, pos_x_q} + (W+1)'(MOVE_STEP)) > (W+1)'(X_MAX)) pos_x_d = W'(X_MAX);
        else                                                        pos_x_d = pos_x_q + W'(MOVE_STEP);
      end
      if (relaunch) begin
        vel_d   = JUMP_VEL;
        state_d = RISE;
      end else begin
        case (state_q)
          GROUNDED: begin
            if (jump_req_q) begin
              vel_d   = JUMP_VEL;
              state_d = RISE;
            end else if (!on_ground_i && (pos_y_q < W'(GROUND_Y))) begin
              vel_d   = GRAV_V;
              state_d = FALL;
            end
          end
          RISE: begin
            if (rise_sum <= Y_MIN_S) begin
              pos_y_d = W'(Y_MIN);
              vel_d   = '0;
              state_d = FALL;
            end else begin
              pos_y_d = clamp_y(rise_sum);
              vel_d   = vel_inc;
              if (!vel_inc[7]) state_d = FALL;
            end
          end
          FALL: begin
            pos_y_d = clamp_y(fall_sum);
            if (land) begin
              vel_d   = '0;
              state_d = GROUNDED;
            end else begin
              vel_d   = fall_v;
            end
          end
          default: state_d = GROUNDED;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
      jump_prev_q  <= 1'b0;
      jump_req_q   <= 1'b0;
      flip_q       <= 1'b0;
      pos_x_q      <= W'(SPAWN_X);
      pos_y_q      <= W'(GROUND_Y);
      vel_q        <= '0;
      state_q      <= GROUNDED;
    end else begin
      if (cnt_q == CW'(FRAME_TICKS - 1)) begin
        cnt_q        <= '0;
        frame_tick_q <= 1'b1;
      end else begin
        cnt_q        <= cnt_q + 1'b1;
        frame_tick_q <= 1'b0;
      end
      // A new key edge outranks the frame that consumes the previous request.
      jump_prev_q <= stepjump_i;
      if (stepjump_i && !jump_prev_q) jump_req_q <= 1'b1;
      else if (frame_active)          jump_req_q <= 1'b0;
      if (game_active_i == 2'd1) begin
        if (left_only)       flip_q <= 1'b1;
        else if (right_only) flip_q <= 1'b0;
      end
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vel_q   <= vel_d;
      state_q <= state_d;
    end
  end

  assign pos_x_o      = pos_x_q;
  assign pos_y_o      = pos_y_q;
  assign vel_y_o      = vel_q;
  assign flip_h_o     = flip_q;
  assign airborne_o   = (state_q != GROUNDED);
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Directed bench for char_motion_ctrl: a default-ceiling unit and a low-ceiling (Y_MIN=600) unit share stimulus.
module tb_char_motion_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, game_start, stepleft, stepright, stepjump, on_ground;
  logic [1:0]  game_active;
  logic [11:0] a_x, a_y, c_x, c_y;
  logic [7:0]  a_v, c_v;
  logic        a_flip, c_flip, a_air, c_air, a_tick, c_tick;

  int total = 0;
  int bad   = 0;

  char_motion_ctrl #(.FRAME_TICKS(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .game_active_i(game_active), .game_start_i(game_start),
    .stepleft_i(stepleft), .stepright_i(stepright), .stepjump_i(stepjump), .on_ground_i(on_ground),
    .pos_x_o(a_x), .pos_y_o(a_y), .vel_y_o(a_v), .flip_h_o(a_flip), .airborne_o(a_air),
    .frame_tick_o(a_tick)
  );

  char_motion_ctrl #(.FRAME_TICKS(4), .Y_MIN(600)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .game_active_i(game_active), .game_start_i(game_start),
    .stepleft_i(stepleft), .stepright_i(stepright), .stepjump_i(stepjump), .on_ground_i(on_ground),
    .pos_x_o(c_x), .pos_y_o(c_y), .vel_y_o(c_v), .flip_h_o(c_flip), .airborne_o(c_air),
    .frame_tick_o(c_tick)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  function automatic int sv8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Returns #1 after the edge on which the pending frame update lands.
  task automatic next_frame();
    int n = 0;
    while (a_tick !== 1'b1 && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 16) check("frame_tick_timeout", int'(a_tick), 1);
    @(posedge clk); #1;
  endtask

  task automatic frames(input int cnt);
    for (int i = 0; i < cnt; i++) next_frame();
  endtask

  initial begin
    rst_n = 1'b0; game_start = 1'b0; stepleft = 1'b0; stepright = 1'b0;
    stepjump = 1'b0; on_ground = 1'b1; game_active = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", int'(a_x), 204);
    check("rst_y", int'(a_y), 689);
    check("rst_vel", sv8(a_v), 0);
    check("rst_flip", int'(a_flip), 0);
    check("rst_air", int'(a_air), 0);
    check("rst_tick", int'(a_tick), 0);
    rst_n = 1'b1;

    // horizontal walk and clamping
    game_active = 2'd1; stepright = 1'b1;
    frames(3);
    check("right3_x", int'(a_x), 219);
    check("right3_tick_low", int'(a_tick), 0);
    stepright = 1'b0; stepleft = 1'b1;
    frames(1);
    check("left1_x", int'(a_x), 214);
    check("left1_flip", int'(a_flip), 1);
    stepright = 1'b1;
    frames(2);
    check("both_x", int'(a_x), 214);
    check("both_flip", int'(a_flip), 1);
    stepleft = 1'b0;
    frames(157);
    check("near_max_x", int'(a_x), 999);
    check("right_flip", int'(a_flip), 0);
    frames(1);
    check("clamp_max_x", int'(a_x), 1000);
    frames(1);
    check("hold_max_x", int'(a_x), 1000);
    stepright = 1'b0; stepleft = 1'b1;
    frames(195);
    check("near_min_x", int'(a_x), 25);
    frames(1);
    check("clamp_min_x", int'(a_x), 24);
    frames(1);
    check("hold_min_x", int'(a_x), 24);
    check("walk_y", int'(a_y), 689);
    check("walk_air", int'(a_air), 0);
    stepleft = 1'b0;

    // jump with the key held for the whole flight
    stepjump = 1'b1;
    next_frame();
    check("launch_vel", sv8(a_v), -18);
    check("launch_y", int'(a_y), 689);
    check("launch_air", int'(a_air), 1);
    check("c_launch_vel", sv8(c_v), -18);
    on_ground = 1'b0;
    next_frame();
    check("rise1_y", int'(a_y), 671);
    check("rise1_vel", sv8(a_v), -17);
    frames(5);
    check("f7_y", int'(a_y), 596);
    check("f7_vel", sv8(a_v), -12);
    check("c_ceiling_y", int'(c_y), 600);
    check("c_ceiling_vel", sv8(c_v), 0);
    check("c_ceiling_air", int'(c_air), 1);
    next_frame();
    check("f8_y", int'(a_y), 584);
    check("c_f8_y", int'(c_y), 601);
    check("c_f8_vel", sv8(c_v), 1);

    // paused mid-air: everything holds
    game_active = 2'd2; stepright = 1'b1;
    frames(3);
    check("pause_y", int'(a_y), 584);
    check("pause_vel", sv8(a_v), -11);
    check("pause_x", int'(a_x), 24);
    check("pause_flip", int'(a_flip), 1);
    check("c_pause_y", int'(c_y), 601);
    stepright = 1'b0; game_active = 2'd1;
    next_frame();
    check("resume_y", int'(a_y), 573);
    frames(10);
    check("apex_y", int'(a_y), 518);
    check("apex_vel", sv8(a_v), 0);
    check("apex_air", int'(a_air), 1);
    check("c_f19_y", int'(c_y), 678);
    check("c_f19_vel", sv8(c_v), 12);
    next_frame();
    check("fall1_y", int'(a_y), 519);
    check("c_land_y", int'(c_y), 689);
    check("c_land_air", int'(c_air), 0);
    frames(18);
    check("f38_y", int'(a_y), 680);
    check("f38_vel", sv8(a_v), 12);
    next_frame();
    check("land_y", int'(a_y), 689);
    check("land_vel", sv8(a_v), 0);
    check("land_air", int'(a_air), 0);
    frames(2);
    check("held_no_rejump_air", int'(a_air), 0);
    check("held_no_rejump_y", int'(a_y), 689);

    // airborne jump requests
    stepjump = 1'b0;
    @(posedge clk); #1;
    stepjump = 1'b1;
    next_frame();
    check("jump2_vel", sv8(a_v), -18);
    stepjump = 1'b0;
    next_frame();
    check("jump2_r1_y", int'(a_y), 671);
    @(posedge clk); #1;
    stepjump = 1'b1;
    next_frame();
`ifdef CHAR_DOUBLE_JUMP_EN
    check("dj_second_y", int'(a_y), 671);
    check("dj_second_vel", sv8(a_v), -18);
`else
    check("air_req_y", int'(a_y), 654);
    check("air_req_vel", sv8(a_v), -16);
`endif
    stepjump = 1'b0;
    @(posedge clk); #1;
    stepjump = 1'b1;
    next_frame();
`ifdef CHAR_DOUBLE_JUMP_EN
    check("dj_third_y", int'(a_y), 653);
    check("dj_third_vel", sv8(a_v), -17);
`else
    check("air_req2_y", int'(a_y), 638);
    check("air_req2_vel", sv8(a_v), -15);
`endif
    stepjump = 1'b0;

    // respawn mid-air keeps facing direction
    game_start = 1'b1;
    @(posedge clk); #1;
    game_start = 1'b0;
    check("start_x", int'(a_x), 204);
    check("start_y", int'(a_y), 689);
    check("start_vel", sv8(a_v), 0);
    check("start_air", int'(a_air), 0);
    check("start_flip", int'(a_flip), 1);

    // reset during the rise
    stepjump = 1'b1;
    next_frame();
    next_frame();
    check("pre_rst_y", int'(a_y), 671);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrise_rst_y", int'(a_y), 689);
    check("midrise_rst_vel", sv8(a_v), 0);
    check("midrise_rst_air", int'(a_air), 0);
    check("midrise_rst_flip", int'(a_flip), 0);
    check("midrise_rst_tick", int'(a_tick), 0);
    rst_n = 1'b1;
    stepjump = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
